// File: rtl/mem_access_unit.sv
// Memory access unit: MAR/MDR/stride registers driving a held read/write strobe to data
// memory, with post-increment addressing, busy output and a sticky timeout/conflict error.
module mem_access_unit #(
  parameter int unsigned BUS_W       = 24,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned STRIDE_W    = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [BUS_W-1:0]  c_bus,
  input  logic              mar_load,
  input  logic              mdr_load,
  input  logic              stride_load,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic              addr_inc,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              err
);

  // Counter only needs to reach TIMEOUT_CYC-1.
  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {StIdle, StRdWait, StWrWait} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic [STRIDE_W-1:0] stride_q, stride_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                inc_pend_q, inc_pend_d;
  logic                err_q, err_d;
  logic                set_err;

  always_comb begin
    state_d    = state_q;
    mar_d      = mar_q;
    mdr_d      = mdr_q;
    stride_d   = stride_q;
    cnt_d      = cnt_q;
    inc_pend_d = inc_pend_q;
    set_err    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mar_load)    mar_d    = c_bus[ADDR_W-1:0];
        if (mdr_load)    mdr_d    = c_bus[DATA_W-1:0];
        if (stride_load) stride_d = c_bus[STRIDE_W-1:0];
        inc_pend_d = addr_inc;
        cnt_d      = '0;
        if (rd_req && wr_req) set_err = 1'b1;
        else if (rd_req)      state_d = StRdWait;
        else if (wr_req)      state_d = StWrWait;
      end
      StRdWait, StWrWait: begin
        if (mem_ready) begin
          if (state_q == StRdWait) mdr_d = mem_rdata;
          if (inc_pend_q) mar_d = mar_q + ADDR_W'(stride_q);
          state_d = StIdle;
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == CntW'(TIMEOUT_CYC - 1))) begin
          set_err = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // A new error outranks a simultaneous clear.
    err_d = set_err | (err_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      mar_q      <= '0;
      mdr_q      <= '0;
      stride_q   <= STRIDE_W'(1);
      cnt_q      <= '0;
      inc_pend_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (enable) begin
      state_q    <= state_d;
      mar_q      <= mar_d;
      mdr_q      <= mdr_d;
      stride_q   <= stride_d;
      cnt_q      <= cnt_d;
      inc_pend_q <= inc_pend_d;
      err_q      <= err_d;
    end
  end

  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign mdr_out   = mdr_q;
  assign mem_rd    = (state_q == StRdWait);
  assign mem_wr    = (state_q == StWrWait);
  assign busy      = (state_q != StIdle);
  assign err       = err_q;

  // Upper C-bus bits beyond the widest register are not used.
  logic unused_c_bus;
  assign unused_c_bus = ^c_bus;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized traffic compared
// each cycle against a transaction-level model of the unit.
module tb_mem_access_unit;

  localparam int unsigned BusW    = 24;
  localparam int unsigned DataW   = 8;
  localparam int unsigned AddrW   = 16;
  localparam int unsigned StrideW = 8;
  localparam int unsigned To      = 4;

  logic             clk = 1'b0;
  logic             reset_n, enable;
  logic [BusW-1:0]  c_bus;
  logic             mar_load, mdr_load, stride_load, rd_req, wr_req, addr_inc, err_clr;
  logic [AddrW-1:0] mem_addr;
  logic [DataW-1:0] mem_wdata, mem_rdata, mdr_out;
  logic             mem_rd, mem_wr, mem_ready, busy, err;

  always #5 clk = ~clk;

  mem_access_unit #(
    .BUS_W(BusW), .DATA_W(DataW), .ADDR_W(AddrW), .STRIDE_W(StrideW), .TIMEOUT_CYC(To)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .c_bus(c_bus),
    .mar_load(mar_load), .mdr_load(mdr_load), .stride_load(stride_load),
    .rd_req(rd_req), .wr_req(wr_req), .addr_inc(addr_inc), .err_clr(err_clr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready),
    .mdr_out(mdr_out), .busy(busy), .err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: pending access kind (0 none, 1 read, 2 write) and cycles waited.
  logic [AddrW-1:0]   m_mar;
  logic [DataW-1:0]   m_mdr;
  logic [StrideW-1:0] m_stride;
  int                 m_kind, m_waited;
  bit                 m_inc, m_err, m_new_err;
  bit                 m_valid = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_mar = '0; m_mdr = '0; m_stride = 8'd1; m_kind = 0; m_waited = 0;
      m_inc = 1'b0; m_err = 1'b0; m_valid = 1'b1;
    end else if (enable && m_valid) begin
      m_new_err = 1'b0;
      if (m_kind == 0) begin
        if (mar_load)    m_mar    = c_bus[AddrW-1:0];
        if (mdr_load)    m_mdr    = c_bus[DataW-1:0];
        if (stride_load) m_stride = c_bus[StrideW-1:0];
        if (rd_req && wr_req) m_new_err = 1'b1;
        else if (rd_req)      m_kind = 1;
        else if (wr_req)      m_kind = 2;
        m_inc    = addr_inc;
        m_waited = 0;
      end else if (mem_ready) begin
        if (m_kind == 1) m_mdr = mem_rdata;
        if (m_inc) m_mar = m_mar + {8'h00, m_stride};
        m_kind = 0;
      end else begin
        m_waited++;
        if (To != 0 && m_waited == To) begin
          m_kind    = 0;
          m_new_err = 1'b1;
        end
      end
      if (m_new_err)    m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("mem_addr", 32'(mem_addr), 32'(m_mar));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_mdr));
      chk("mdr_out", 32'(mdr_out), 32'(m_mdr));
      chk("mem_rd", 32'(mem_rd), 32'(m_kind == 1));
      chk("mem_wr", 32'(mem_wr), 32'(m_kind == 2));
      chk("busy", 32'(busy), 32'(m_kind != 0));
      chk("err", 32'(err), 32'(m_err));
    end
  end

  task automatic idle_inputs();
    mar_load = 0; mdr_load = 0; stride_load = 0; rd_req = 0; wr_req = 0;
    addr_inc = 0; err_clr = 0;
  endtask

  logic [7:0]  rv[3];
  logic [15:0] ea[3];
  int          cnt;

  initial begin
    idle_inputs();
    reset_n = 0; enable = 1; c_bus = '0; mem_rdata = '0; mem_ready = 0;
    rv[0] = 8'h11; rv[1] = 8'h22; rv[2] = 8'h33;
    ea[0] = 16'hFFFE; ea[1] = 16'h0000; ea[2] = 16'h0002;

    repeat (2) @(negedge clk);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_mdr", 32'(mdr_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);

    // Write with three strobe cycles
    reset_n = 1; c_bus = 24'h001234; mar_load = 1;
    @(negedge clk);
    mar_load = 0; c_bus = 24'h0000A5; mdr_load = 1; wr_req = 1;
    @(negedge clk);
    idle_inputs();
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_wr) begin
        cnt++;
        chk("wr_addr", 32'(mem_addr), 32'h1234);
        chk("wr_data", 32'(mem_wdata), 32'hA5);
        chk("wr_busy", 32'(busy), 32'h1);
      end
      mem_ready = mem_wr && (cnt == 3);
      @(negedge clk);
    end
    chk("wr_cycles", 32'(cnt), 32'd3);
    chk("wr_err", 32'(err), 32'h0);

    // Strided read walk with wrap
    c_bus = 24'h2; stride_load = 1;
    @(negedge clk);
    stride_load = 0; c_bus = 24'h00FFFE; mar_load = 1;
    @(negedge clk);
    mar_load = 0;
    for (int i = 0; i < 3; i++) begin
      rd_req = 1; addr_inc = 1;
      @(negedge clk);
      rd_req = 0; addr_inc = 0;
      chk("walk_rd", 32'(mem_rd), 32'h1);
      chk("walk_addr", 32'(mem_addr), 32'(ea[i]));
      mem_ready = 1; mem_rdata = rv[i];
      @(negedge clk);
      mem_ready = 0;
      chk("walk_mdr", 32'(mdr_out), 32'(rv[i]));
      chk("walk_busy", 32'(busy), 32'h0);
    end
    chk("walk_final", 32'(mem_addr), 32'h0004);

    // Timeout
    rd_req = 1;
    @(negedge clk);
    rd_req = 0; cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_rd) cnt++;
      @(negedge clk);
    end
    chk("to_cycles", 32'(cnt), 32'd4);
    chk("to_err", 32'(err), 32'h1);
    chk("to_mdr", 32'(mdr_out), 32'h33);
    chk("to_addr", 32'(mem_addr), 32'h0004);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("to_clr", 32'(err), 32'h0);

    // Conflict, then load ignored while waiting
    rd_req = 1; wr_req = 1;
    @(negedge clk);
    idle_inputs();
    chk("cf_busy", 32'(busy), 32'h0);
    chk("cf_strobe", 32'({mem_rd, mem_wr}), 32'h0);
    chk("cf_err", 32'(err), 32'h1);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0; rd_req = 1;
    @(negedge clk);
    rd_req = 0; c_bus = 24'h005555; mar_load = 1;
    @(negedge clk);
    mar_load = 0; mem_ready = 1; mem_rdata = 8'h44;
    @(negedge clk);
    mem_ready = 0;
    chk("ign_addr", 32'(mem_addr), 32'h0004);
    chk("ign_mdr", 32'(mdr_out), 32'h44);

    // Freeze mid-read
    rd_req = 1; mem_rdata = 8'h66;
    @(negedge clk);
    rd_req = 0; enable = 0; mem_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("frz_busy", 32'(busy), 32'h1);
    end
    enable = 1;
    @(negedge clk);
    mem_ready = 0;
    chk("frz_done", 32'(busy), 32'h0);
    chk("frz_mdr", 32'(mdr_out), 32'h66);

    // Abort write with reset
    c_bus = 24'h000777; mar_load = 1; wr_req = 1;
    @(negedge clk);
    idle_inputs();
    chk("ab_wr", 32'(mem_wr), 32'h1);
    chk("ab_addr", 32'(mem_addr), 32'h0777);
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    chk("ab_wr_off", 32'(mem_wr), 32'h0);
    chk("ab_busy", 32'(busy), 32'h0);
    chk("ab_addr0", 32'(mem_addr), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset_n     = ($urandom_range(0, 199) != 0);
      enable      = ($urandom_range(0, 9) != 0);
      c_bus       = BusW'($urandom);
      mar_load    = ($urandom_range(0, 3) == 0);
      mdr_load    = ($urandom_range(0, 3) == 0);
      stride_load = ($urandom_range(0, 5) == 0);
      rd_req      = ($urandom_range(0, 2) == 0);
      wr_req      = ($urandom_range(0, 2) == 0);
      addr_inc    = ($urandom_range(0, 1) == 0);
      err_clr     = ($urandom_range(0, 7) == 0);
      mem_ready   = ($urandom_range(0, 3) == 0);
      mem_rdata   = DataW'($urandom);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
